// File: rtl/mem_line_responder_if.sv
// rtl/mem_line_responder_if.sv - cache-miss port bundle between CPU and line responder
//
// Purpose: groups the instruction/data miss handshake, address, write data and
// returned lines so the responder and its requester share one port.
// Signals:
//   i_req/i_addr        instruction line-fill request (level) and byte address
//   i_ack/i_line        one-cycle completion pulse and 128-bit instruction line
//   d_req/d_we/d_addr   data request (level), write flag, byte address
//   d_wdata             data write word
//   d_ack/d_line        one-cycle completion pulse and 128-bit data line
//   busy                responder not idle
// Modports: master = requester (CPU side), slave = responder.
interface mem_line_responder_if;
  logic         i_req;
  logic [31:0]  i_addr;
  logic         i_ack;
  logic [127:0] i_line;
  logic         d_req;
  logic         d_we;
  logic [31:0]  d_addr;
  logic [31:0]  d_wdata;
  logic         d_ack;
  logic [127:0] d_line;
  logic         busy;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    input  i_ack, i_line, d_ack, d_line, busy
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    output i_ack, i_line, d_ack, d_line, busy
  );
endinterface

// File: rtl/mem_line_responder.sv
// rtl/mem_line_responder.sv - latency-programmable line-fill / word-write memory responder
//
// Purpose: services instruction line fills, data line fills and data word
// writes from one word-addressed store, one transaction at a time.
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset
//   bus   mem_line_responder_if.slave (requests in, acks/lines/busy out)
// Parameters:
//   ADDR_WIDTH  word-address bits of the store (depth 2^ADDR_WIDTH words)
//   LATENCY     wait cycles before burst/write, 1..15
module mem_line_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  mem_line_responder_if.slave  bus
);

  localparam int         DEPTH       = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT    = 4'(LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_BURST,
    S_WRITE,
    S_RESP
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_side_d;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic [31:0]             r_wdata;
  logic [3:0]              r_cnt;
  logic [1:0]              r_k;
  logic [127:0]            r_i_line;
  logic [127:0]            r_d_line;
  logic [31:0]             r_mem [0:DEPTH-1];

  logic                    w_grant;
  logic [31:0]             w_req_addr;
  logic [ADDR_WIDTH-1:0]   w_rd_idx;
  logic [31:0]             w_rdata;
  logic                    w_unused_addr_bits;

  // Data side wins arbitration: a pending data miss belongs to the older instruction.
  assign w_grant    = (r_state == S_IDLE) && (bus.d_req || bus.i_req);
  assign w_req_addr = bus.d_req ? bus.d_addr : bus.i_addr;

  // Upper bits alias; byte-lane bits are meaningless for a word store.
  assign w_unused_addr_bits = ^{w_req_addr[31:ADDR_WIDTH+2], w_req_addr[1:0]};

  // Burst reads walk the aligned line containing the captured index.
  assign w_rd_idx = {r_idx[ADDR_WIDTH-1:2], r_k};
  assign w_rdata  = r_mem[w_rd_idx];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.d_req || bus.i_req) w_next = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_next = r_we ? S_WRITE : S_BURST;
      S_BURST: if (r_k == 2'd3) w_next = S_RESP;
      S_WRITE: w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_side_d <= 1'b0;
      r_we     <= 1'b0;
      r_idx    <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
      r_k      <= '0;
      r_i_line <= '0;
      r_d_line <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_side_d <= bus.d_req;
            r_we     <= bus.d_req & bus.d_we;
            r_idx    <= w_req_addr[ADDR_WIDTH+1:2];
            r_wdata  <= bus.d_req ? bus.d_wdata : 32'd0;
            r_cnt    <= CNT_INIT;
            r_k      <= 2'd0;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        end
        S_BURST: begin
          r_k <= r_k + 2'd1;
          if (r_side_d) r_d_line[{r_k, 5'd0} +: 32] <= w_rdata;
          else          r_i_line[{r_k, 5'd0} +: 32] <= w_rdata;
        end
        default: ;
      endcase
    end
  end

  // Store contents survive reset and are undefined until written.
  always_ff @(posedge clk) begin
    if (r_state == S_WRITE) r_mem[r_idx] <= r_wdata;
  end

  assign bus.i_ack  = (r_state == S_RESP) && !r_side_d;
  assign bus.d_ack  = (r_state == S_RESP) &&  r_side_d;
  assign bus.i_line = r_i_line;
  assign bus.d_line = r_d_line;
  assign bus.busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_line_responder.sv
// tb/tb_mem_line_responder.sv - self-checking bench for mem_line_responder
module tb_mem_line_responder;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  mem_line_responder_if bus();

  mem_line_responder #(.ADDR_WIDTH(10), .LATENCY(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           side_d;
    bit           we;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [127:0] exp_line;
    int           exp_lat;
  } vec_t;

  localparam logic [127:0] L0 = 128'hA000000C_A0000008_DEADBEEF_A0000000;
  localparam logic [127:0] L1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] L2 = 128'h44444444_33333333_22222222_55555555;

  vec_t vecs [0:13];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_txn(input bit side_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat);
    bus.d_we = we;
    if (side_d) begin
      bus.d_addr  = addr;
      bus.d_wdata = wdata;
      bus.d_req   = 1'b1;
    end else begin
      bus.i_addr = addr;
      bus.i_req  = 1'b1;
    end
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if ((side_d && bus.d_ack) || (!side_d && bus.i_ack)) begin
        lat = n;
        break;
      end
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    @(posedge clk); #1;
    chk("ack_one_cycle", 128'({bus.i_ack, bus.d_ack}), 128'd0);
  endtask

  initial begin
    int  lat;
    int  m;
    bit  early;
    bit  stray;

    checks   = 0;
    failures = 0;

    vecs[0]  = '{1, 1, 32'h0000_0040, 32'h1111_1111, 128'd0, 6};
    vecs[1]  = '{1, 1, 32'h0000_0044, 32'h2222_2222, 128'd0, 6};
    vecs[2]  = '{1, 1, 32'h0000_0048, 32'h3333_3333, 128'd0, 6};
    vecs[3]  = '{1, 1, 32'h0000_004C, 32'h4444_4444, 128'd0, 6};
    vecs[4]  = '{0, 0, 32'h0000_0048, 32'h0,         L1,     9};
    vecs[5]  = '{1, 0, 32'h0000_0040, 32'h0,         L1,     9};
    vecs[6]  = '{1, 1, 32'h0000_0000, 32'hA000_0000, L1,     6};
    vecs[7]  = '{1, 1, 32'h0000_0004, 32'hDEAD_BEEF, L1,     6};
    vecs[8]  = '{1, 1, 32'h0000_0008, 32'hA000_0008, L1,     6};
    vecs[9]  = '{1, 1, 32'h0000_100C, 32'hA000_000C, L1,     6};
    vecs[10] = '{1, 0, 32'h0000_1000, 32'h0,         L0,     9};
    vecs[11] = '{0, 0, 32'h0000_0007, 32'h0,         L0,     9};
    vecs[12] = '{1, 1, 32'h0000_0043, 32'h5555_5555, L0,     6};
    vecs[13] = '{1, 0, 32'h0000_0040, 32'h0,         L2,     9};

    rstn        = 1'b0;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",   128'(bus.busy), 128'd0);
    chk("reset_acks",   128'({bus.i_ack, bus.d_ack}), 128'd0);
    chk("reset_i_line", bus.i_line, 128'd0);
    chk("reset_d_line", bus.d_line, 128'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 128'(bus.busy), 128'd0);

    // Table: writes report d_line (must stay unchanged), reads report their side's line.
    for (int v = 0; v < 14; v++) begin
      do_txn(vecs[v].side_d, vecs[v].we, vecs[v].addr, vecs[v].wdata, lat);
      chk($sformatf("vec%0d_latency", v), 128'(lat), 128'(vecs[v].exp_lat));
      if (vecs[v].side_d)
        chk($sformatf("vec%0d_d_line", v), bus.d_line, vecs[v].exp_line);
      else
        chk($sformatf("vec%0d_i_line", v), bus.i_line, vecs[v].exp_line);
    end

    // Simultaneous requests: data first, instruction waits and is not dropped.
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h0000_0040;
    bus.i_addr = 32'h0000_0040;
    bus.d_req  = 1'b1;
    bus.i_req  = 1'b1;
    lat   = -1;
    early = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (bus.i_ack) early = 1'b1;
      if (bus.d_ack) begin
        lat = n;
        break;
      end
    end
    chk("both_d_latency", 128'(lat), 128'd9);
    chk("both_no_early_i_ack", 128'(early), 128'd0);
    chk("both_d_line", bus.d_line, L2);
    bus.d_req = 1'b0;
    m = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (bus.i_ack) begin
        m = n;
        break;
      end
    end
    bus.i_req = 1'b0;
    chk("both_i_after_d_ge9", 128'(m >= 9), 128'd1);
    chk("both_i_line", bus.i_line, L2);
    @(posedge clk); #1;

    // Captured request frozen: address/we change and req drop after grant.
    do_txn(1'b1, 1'b0, 32'h0000_0000, 32'h0, lat);
    chk("frz_pre_d_line", bus.d_line, L0);
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h0000_0040;
    bus.d_req  = 1'b1;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (n == 2) begin
        bus.d_addr = 32'h0000_0080;
        bus.d_we   = 1'b1;
        bus.d_req  = 1'b0;
      end
      if (bus.d_ack) begin
        lat = n;
        break;
      end
    end
    chk("frz_latency", 128'(lat), 128'd9);
    chk("frz_d_line", bus.d_line, L2);
    bus.d_we = 1'b0;
    @(posedge clk); #1;

    // Reset during BURST aborts the transaction.
    bus.i_addr = 32'h0000_0040;
    bus.i_req  = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    chk("mid_burst_busy", 128'(bus.busy), 128'd1);
    rstn      = 1'b0;
    bus.i_req = 1'b0;
    #1;
    chk("rst_busy",   128'(bus.busy), 128'd0);
    chk("rst_i_line", bus.i_line, 128'd0);
    chk("rst_d_line", bus.d_line, 128'd0);
    stray = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.i_ack || bus.d_ack) stray = 1'b1;
    end
    rstn = 1'b1;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.i_ack || bus.d_ack || bus.busy) stray = 1'b1;
    end
    chk("rst_no_ack", 128'(stray), 128'd0);
    do_txn(1'b0, 1'b0, 32'h0000_0040, 32'h0, lat);
    chk("post_rst_latency", 128'(lat), 128'd9);
    chk("post_rst_i_line", bus.i_line, L2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
